axi_lite_cmd_master: RTL and testbench

// - Simple command/response port converted into single AXI4-Lite master transactions on the GPIO slave's s_axi_* bus.
// - Upstream neighbour of the AXI GPIO wrapper: test sequencers and control logic use cmd/rsp and never drive AXI channels.
// - One transaction outstanding at a time; every AXI output is registered.

---
 rtl/axi_lite_cmd_master_pkg.sv | 19 +
 rtl/axi_lite_cmd_master.sv | 184 ++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_pkg.sv
// rtl/axi_lite_cmd_master_pkg.sv - shared types and constants for the cmd/rsp to AXI4-Lite master
package axi_lite_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } cmd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [8:0] GPIO_DATA = 9'h000;
    localparam logic [8:0] GPIO_TRI  = 9'h004;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - cmd/rsp port to single AXI4-Lite transactions; optional AXI_LITE_CMD_TIMEOUT_EN
module axi_lite_cmd_master
    import axi_lite_cmd_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(3);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("axi_lite_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    cmd_state_t state;

`ifdef AXI_LITE_CMD_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TO_LAST);
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
`ifdef AXI_LITE_CMD_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr & ADDR_ALIGN;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            m_axi_araddr  <= cmd_addr & ADDR_ALIGN;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                // AW and W complete independently; leave only when neither is still pending.
                ST_WR_REQ: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
`ifdef AXI_LITE_CMD_TIMEOUT_EN
                        to_cnt       <= '0;
`endif
                    end
                end

                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
`ifdef AXI_LITE_CMD_TIMEOUT_EN
                    else if (to_hit) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= RESP_SLVERR;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_RESP;
`ifdef AXI_LITE_CMD_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end

                ST_RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_resp     <= m_axi_rresp;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
`ifdef AXI_LITE_CMD_TIMEOUT_EN
                    else if (to_hit) begin
                        m_axi_rready <= 1'b0;
                        rsp_resp     <= RESP_SLVERR;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                // Raising cmd_ready on the way out keeps the zero-wait command period at 4 cycles.
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - scoreboard bench for axi_lite_cmd_master against a GPIO slave model
module tb_axi_lite_cmd_master;
    import axi_lite_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [8:0]  awaddr, araddr;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [33:0] exp_q[$];

    // slave model state
    logic [31:0] gpio_data = '0, gpio_tri = '0, gpio_io_i = '0;
    logic        fast = 1'b0, no_b = 1'b0, hold_aw = 1'b0;
    logic        aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [8:0]  aw_l = '0, ar_l = '0;
    logic [31:0] w_l = '0, rd_l = '0;
    logic [3:0]  s_l = '0;
    logic [1:0]  bresp_l = '0, rresp_l = '0;
    int          b_wait = 0, r_wait = 0;
    logic        st_aw = 1'b0, st_w = 1'b0, st_ar = 1'b0;
    logic [8:0]  aw_prev = '0, ar_prev = '0;
    logic [35:0] w_prev = '0;

    axi_lite_cmd_master #(.ADDR_W(9), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Handshakes and AXI hold rules are observed on the active edge, acted on at the falling edge.
    always @(posedge clk) begin
        cyc++;
        if (st_aw) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, aw_prev}));
        if (st_w)  chk("w_hold", 64'({wvalid, wdata, wstrb}), 64'({1'b1, w_prev}));
        if (st_ar) chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, ar_prev}));
        st_aw = resetn && awvalid && !awready;
        st_w  = resetn && wvalid && !wready;
        st_ar = resetn && arvalid && !arready;
        aw_prev = awaddr; w_prev = {wdata, wstrb}; ar_prev = araddr;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (aw_hs) aw_l = awaddr;
        if (w_hs) begin w_l = wdata; s_l = wstrb; end
        if (ar_hs) ar_l = araddr;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            {aw_got, w_got, b_pend, r_pend, awready, wready, arready, bvalid, rvalid} = '0;
            gpio_data = '0; gpio_tri = '0;
        end else begin
            if (b_hs) bvalid = 1'b0;
            if (r_hs) rvalid = 1'b0;
            if (aw_hs) aw_got = 1'b1;
            if (w_hs) w_got = 1'b1;
            if (aw_got && w_got) begin
                bresp_l = RESP_OKAY;
                if (aw_l == GPIO_DATA) begin
                    for (int i = 0; i < 4; i++) if (s_l[i]) gpio_data[i*8 +: 8] = w_l[i*8 +: 8];
                end else if (aw_l == GPIO_TRI) begin
                    for (int i = 0; i < 4; i++) if (s_l[i]) gpio_tri[i*8 +: 8] = w_l[i*8 +: 8];
                end else if (aw_l > 9'h00C) begin
                    bresp_l = RESP_SLVERR;
                end
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
                b_wait = fast ? 0 : int'($urandom_range(0, 2));
            end
            if (ar_hs) begin
                rresp_l = RESP_OKAY;
                if (ar_l == GPIO_DATA)     rd_l = (gpio_io_i & gpio_tri) | (gpio_data & ~gpio_tri);
                else if (ar_l == GPIO_TRI) rd_l = gpio_tri;
                else begin rd_l = '0; if (ar_l > 9'h00C) rresp_l = RESP_SLVERR; end
                r_pend = 1'b1;
                r_wait = fast ? 0 : int'($urandom_range(0, 2));
            end
            if (b_pend && !no_b) begin
                if (b_wait == 0) begin bvalid = 1'b1; bresp = bresp_l; b_pend = 1'b0; end
                else b_wait--;
            end
            if (r_pend) begin
                if (r_wait == 0) begin rvalid = 1'b1; rdata = rd_l; rresp = rresp_l; r_pend = 1'b0; end
                else r_wait--;
            end
            awready = !aw_got && !hold_aw && (fast || $urandom_range(0, 1) == 1);
            wready  = !w_got && (fast || $urandom_range(0, 1) == 1);
            arready = fast || $urandom_range(0, 1) == 1;
        end
    end

    // Called and returns at a falling edge; wait counts cycles with bready/rready high.
    task automatic send(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                        input int hold, output int wait_cyc);
        int n;
        logic [33:0] e;
        logic [33:0] snap;
        exp_q.push_back({exp_rd, exp_resp});
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 9'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        if (wr) begin
            chk("aw_w_issue", 64'({awvalid, wvalid, arvalid}), 64'(3'b110));
            chk("awaddr", 64'(awaddr), 64'(addr & 9'h1FC));
        end else begin
            chk("ar_issue", 64'({awvalid, wvalid, arvalid}), 64'(3'b001));
            chk("araddr", 64'(araddr), 64'(addr & 9'h1FC));
        end
        n = 0; wait_cyc = 0;
        while (!rsp_valid && n < 500) begin
            if (bready || rready) wait_cyc++;
            @(negedge clk); n++;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[33:2]));
        chk("rsp_resp", 64'(rsp_resp), 64'(e[1:0]));
        snap = {rsp_rdata, rsp_resp};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_stable", 64'({rsp_valid, cmd_ready, rsp_rdata, rsp_resp}), 64'({2'b10, snap}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    initial begin
        int w;
        int n;
        int acc[$];
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'(0));
        chk("rst_data", 64'({awaddr, araddr, wstrb, rsp_resp}), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(cmd_ready), 64'(1));

        send(1, GPIO_DATA, 32'hA5A5_0F0F, 4'hF, 32'h0, RESP_OKAY, 0, w);
        chk("gpio_o_a5", 64'(gpio_data), 64'(32'hA5A5_0F0F));
        send(1, GPIO_TRI, 32'hFFFF_FFFF, 4'hF, 32'h0, RESP_OKAY, 0, w);
        gpio_io_i = 32'h1234_5678;
        send(0, GPIO_DATA | 9'h003, 32'h0, 4'h0, 32'h1234_5678, RESP_OKAY, 0, w);

        send(1, GPIO_TRI, 32'h0, 4'hF, 32'h0, RESP_OKAY, 0, w);
        send(1, GPIO_DATA, 32'h0, 4'hF, 32'h0, RESP_OKAY, 0, w);
        send(1, GPIO_DATA, 32'hFFFF_FFFF, 4'b0011, 32'h0, RESP_OKAY, 0, w);
        chk("gpio_o_strb", 64'(gpio_data), 64'(32'h0000_FFFF));
        send(0, GPIO_DATA, 32'h0, 4'h0, 32'h0000_FFFF, RESP_OKAY, 0, w);

        send(1, GPIO_TRI | 9'h002, 32'hF0F0_0000, 4'hF, 32'h0, RESP_OKAY, 0, w);
        send(0, GPIO_TRI, 32'h0, 4'h0, 32'hF0F0_0000, RESP_OKAY, 5, w);

        send(1, 9'h100, 32'h1111_2222, 4'hF, 32'h0, RESP_SLVERR, 0, w);
        send(0, 9'h100, 32'h0, 4'h0, 32'h0, RESP_SLVERR, 0, w);

        // zero-wait slave with rsp_ready held high: back-to-back commands every 4 cycles
        fast = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO_DATA; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        n = 0;
        while (acc.size() < 4 && n < 100) begin
            if (cmd_ready) acc.push_back(cyc);
            @(negedge clk); n++;
        end
        cmd_valid = 1'b0;
        chk("tput_count", 64'(acc.size()), 64'(4));
        for (int i = 1; i < acc.size(); i++) chk("tput_period", 64'(acc[i] - acc[i-1]), 64'(4));
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        rsp_ready = 1'b0; fast = 1'b0;
        chk("tput_data", 64'(gpio_data), 64'(32'hDEAD_BEEF));

        // reset while AW is stalled
        hold_aw = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO_DATA; cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_aw", 64'(awvalid), 64'(1));
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 64'(0));
        resetn = 1'b1; hold_aw = 1'b0;
        @(negedge clk);
        chk("rst_idle", 64'(cmd_ready), 64'(1));
        send(1, GPIO_DATA, 32'h0BAD_F00D, 4'hF, 32'h0, RESP_OKAY, 0, w);
        chk("gpio_o_post_rst", 64'(gpio_data), 64'(32'h0BAD_F00D));

`ifdef AXI_LITE_CMD_TIMEOUT_EN
        no_b = 1'b1;
        send(1, GPIO_DATA, 32'h7777_7777, 4'hF, 32'h0, RESP_SLVERR, 0, w);
        chk("to_cycles", 64'(w), 64'(16));
        no_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_b_ignored", 64'(bready), 64'(0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
